// File: rtl/reg_file_pkg.sv
// Shared constants for the link-side register file: default geometry,
// named register indices and the readback value returned for illegal addresses.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_REGS = 32;
  localparam int DEF_ERR_W  = 8;

  localparam int ADC_MEM_ADDR_REG = 0;
  localparam int ADC_MEM_WE_REG   = 1;
  localparam int HDR_FIFO_WE_REG  = 2;
  localparam int ERR_CLR_REG      = DEF_N_REGS - 1;

  localparam int ILLEGAL_RDBK = 0;

  // The error-clear command register is always the highest register.
  function automatic int err_clr_reg(input int n_regs);
    return n_regs - 1;
  endfunction

endpackage

// File: rtl/reg_file_ctrl_sat_counter.sv
// Saturating counter for rejected register accesses; can count two events
// in one cycle and never wraps. Cleared by reset or by clr.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc1,
  input  logic             inc2,
  input  logic             clr,
  output logic [ERR_W-1:0] count
);

  localparam logic [ERR_W+1:0] MAX_VAL = {2'b00, {ERR_W{1'b1}}};

  logic [ERR_W-1:0] r_cnt;
  logic [1:0]       w_inc;
  logic [ERR_W+1:0] w_sum;

  assign w_inc = inc2 ? 2'd2 : (inc1 ? 2'd1 : 2'd0);
  assign w_sum = {2'b00, r_cnt} + {{ERR_W{1'b0}}, w_inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_sum > MAX_VAL) begin
      r_cnt <= {ERR_W{1'b1}};
    end else begin
      r_cnt <= w_sum[ERR_W-1:0];
    end
  end

  assign count = r_cnt;

endmodule

// File: rtl/reg_file_ctrl.sv
// Register file behind the Master FPGA link: R/W control and RO status
// registers, strobes, pulse bits, registered readback. Optional macro: AUTO_INC_EN.
module reg_file_ctrl
  import reg_file_pkg::*;
#(
  parameter int                 DATA_W     = DEF_DATA_W,
  parameter int                 N_REGS     = DEF_N_REGS,
  parameter int                 ADDR_W     = $clog2(N_REGS),
  parameter logic [N_REGS-1:0]  RO_MASK    = {N_REGS{1'b0}},
  parameter logic [DATA_W-1:0]  PULSE_MASK = {DATA_W{1'b0}},
  parameter int                 ERR_W      = DEF_ERR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     reg_num_le,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  output logic                     illegal_reg_num,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [N_REGS*DATA_W-1:0] ctrl_regs,
  input  logic [N_REGS*DATA_W-1:0] status_in,
  output logic [N_REGS-1:0]        wr_strobe,
  output logic [N_REGS-1:0]        rd_strobe
);

  localparam logic [ADDR_W-1:0] CLR_ADDR = ADDR_W'(err_clr_reg(N_REGS));

  logic [DATA_W-1:0] r_reg_num;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ro;
  logic              w_wr_req;
  logic              w_wr_acc;
  logic              w_wr_rej;
  logic              w_rd_acc;
  logic              w_rd_rej;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_regs   [N_REGS];
  logic [DATA_W-1:0] w_status [N_REGS];
  logic              w_unused_status;

  assign w_addr          = r_reg_num[ADDR_W-1:0];
  assign illegal_reg_num = |r_reg_num[DATA_W-1:ADDR_W];
  assign w_ro            = RO_MASK[w_addr];

  // rx_data carries an address during reg_num_le, so a coincident write is dropped.
  assign w_wr_req = wr_en & ~reg_num_le;
  assign w_wr_acc = w_wr_req & ~illegal_reg_num & ~w_ro;
  assign w_wr_rej = w_wr_req & (illegal_reg_num | w_ro);
  assign w_rd_acc = rd_en & ~illegal_reg_num;
  assign w_rd_rej = rd_en & illegal_reg_num;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_num <= '0;
    end else if (reg_num_le) begin
      r_reg_num <= rx_data;
`ifdef AUTO_INC_EN
    end else if (rd_en || wr_en) begin
      r_reg_num[ADDR_W-1:0] <= w_addr + 1'b1;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      assign wr_strobe[gi] = w_wr_acc && (w_addr == ADDR_W'(gi));
      assign rd_strobe[gi] = w_rd_acc && (w_addr == ADDR_W'(gi));
      assign ctrl_regs[gi*DATA_W +: DATA_W] = w_regs[gi];

      if (RO_MASK[gi]) begin : g_ro
        assign w_regs[gi]   = '0;
        assign w_status[gi] = status_in[gi*DATA_W +: DATA_W];
      end else begin : g_rw
        logic [DATA_W-1:0] r_val;
        // Pulse bits only become set by a write, so clearing them on every idle cycle is enough.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_val <= '0;
          end else if (wr_strobe[gi]) begin
            r_val <= rx_data;
          end else begin
            r_val <= r_val & ~PULSE_MASK;
          end
        end
        assign w_regs[gi]   = r_val;
        assign w_status[gi] = '0;
      end
    end
  endgenerate

  assign w_unused_status = ^status_in;

  assign w_rd_data = illegal_reg_num ? DATA_W'(ILLEGAL_RDBK)
                   : (w_ro ? w_status[w_addr] : w_regs[w_addr]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= rd_en;
      if (rd_en) begin
        r_tx_data <= w_rd_data;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc1  (w_wr_rej ^ w_rd_rej),
    .inc2  (w_wr_rej & w_rd_rej),
    .clr   (w_wr_acc && (w_addr == CLR_ADDR)),
    .count (err_cnt)
  );

endmodule
